// File: rtl/datapath_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_pkg
// Shared definitions for the register-file datapath sequencer:
//   - datapath geometry (NREG general registers, W-bit data)
//   - sequencer state encoding
//   - opcode constants and the legal-opcode check
//   - bus source encodings
//   - instruction-register field positions
// -----------------------------------------------------------------------------
package datapath_sequencer_pkg;

  localparam int NREG = 4;  // fixed by the 2-bit register fields
  localparam int W    = 8;  // width of the controlled datapath (no W-wide logic here)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_t;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {
    BUS_NONE = 2'b00,
    BUS_EXT  = 2'b01,
    BUS_REG  = 2'b10,
    BUS_G    = 2'b11
  } bus_sel_t;

  // Instruction fields: [7:5] opcode, [4:3] Rx, [2:1] Ry, [0] reserved.
  localparam int IR_OP_MSB = 7;
  localparam int IR_OP_LSB = 5;
  localparam int IR_RX_MSB = 4;
  localparam int IR_RX_LSB = 3;
  localparam int IR_RY_MSB = 2;
  localparam int IR_RY_LSB = 1;

  // ADD and SUB are the only instructions that need the accumulator/G path.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_if
// Instruction handshake plus datapath control bundle.
//   master : instruction issuer / datapath (drives start, instr; observes controls)
//   slave  : the sequencer (observes start, instr; drives handshake and controls)
// Signals:
//   start, instr              instruction valid and 8-bit instruction
//   ready, done, err          handshake / completion / illegal-opcode pulse
//   reg_load, reg_clear       one-hot per-register strobes
//   a_load, g_load, alu_op    accumulator / G loads and ALU operation (1 = sub)
//   bus_sel, rout_sel         bus source and register index for BUS_REG
// -----------------------------------------------------------------------------
interface datapath_sequencer_if;
  import datapath_sequencer_pkg::*;

  logic            start;
  logic [7:0]      instr;
  logic            ready;
  logic            done;
  logic            err;
  logic [NREG-1:0] reg_load;
  logic [NREG-1:0] reg_clear;
  logic            a_load;
  logic            g_load;
  logic            alu_op;
  logic [1:0]      bus_sel;
  logic [1:0]      rout_sel;

  modport master (
    output start, instr,
    input  ready, done, err, reg_load, reg_clear,
           a_load, g_load, alu_op, bus_sel, rout_sel
  );

  modport slave (
    input  start, instr,
    output ready, done, err, reg_load, reg_clear,
           a_load, g_load, alu_op, bus_sel, rout_sel
  );
endinterface

// File: rtl/datapath_sequencer_reg_sel_decoder.sv
// -----------------------------------------------------------------------------
// reg_sel_decoder
// 2-to-4 one-hot decoder with enable; used for the register load and clear
// strobe vectors.
//   i_en      enable; output is all-zero when low
//   i_sel     register index
//   o_onehot  one-hot strobe vector
// -----------------------------------------------------------------------------
module reg_sel_decoder
  import datapath_sequencer_pkg::*;
(
  input  logic            i_en,
  input  logic [1:0]      i_sel,
  output logic [NREG-1:0] o_onehot
);

  assign o_onehot = i_en ? (NREG'(1) << i_sel) : '0;

endmodule

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Multi-cycle controller for a 4-register datapath with accumulator A, ALU
// result register G and a shared bus. One instruction is accepted per
// start&&ready handshake and executed over 1-3 cycles; done pulses in the
// final cycle, err pulses instead for an illegal opcode.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of datapath_sequencer_if (handshake + control outputs)
// All outputs are decoded from the registered state and IR only.
// -----------------------------------------------------------------------------
module datapath_sequencer
  import datapath_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  datapath_sequencer_if.slave  bus
);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:1] r_ir;          // reserved bit 0 is never stored

  logic [2:0]      w_op;
  logic [1:0]      w_rx;
  logic [1:0]      w_ry;
  logic            w_accept;
  logic            w_load_en;
  logic            w_clear_en;
  logic [NREG-1:0] w_reg_load;
  logic [NREG-1:0] w_reg_clear;

  assign w_op     = r_ir[IR_OP_MSB:IR_OP_LSB];
  assign w_rx     = r_ir[IR_RX_MSB:IR_RX_LSB];
  assign w_ry     = r_ir[IR_RY_MSB:IR_RY_LSB];
  assign w_accept = (r_state == ST_IDLE) && bus.start;

  // State and instruction register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_ir <= bus.instr[7:1];
      end
    end
  end

  // Next-state logic.
  // NOTE: the default assignment at the top of each combinational block
  // guarantees every path drives every output, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.start) w_next_state = ST_T1;
      ST_T1:   w_next_state = is_alu_op(w_op) ? ST_T2 : ST_IDLE;
      ST_T2:   w_next_state = ST_T3;
      ST_T3:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode (Moore: state + IR only).
  always_comb begin
    bus.ready    = (r_state == ST_IDLE);
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.a_load   = 1'b0;
    bus.g_load   = 1'b0;
    bus.alu_op   = 1'b0;
    bus.bus_sel  = BUS_NONE;
    bus.rout_sel = 2'b00;
    w_load_en    = 1'b0;
    w_clear_en   = 1'b0;

    unique case (r_state)
      ST_T1: begin
        unique case (w_op)
          OP_CLR: begin
            w_clear_en = 1'b1;
            bus.done   = 1'b1;
          end
          OP_LDI: begin
            bus.bus_sel = BUS_EXT;
            w_load_en   = 1'b1;
            bus.done    = 1'b1;
          end
          OP_MOV: begin
            bus.bus_sel  = BUS_REG;
            bus.rout_sel = w_ry;
            w_load_en    = 1'b1;
            bus.done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            // First operand (Rx) into the accumulator.
            bus.bus_sel  = BUS_REG;
            bus.rout_sel = w_rx;
            bus.a_load   = 1'b1;
          end
          default: bus.err = 1'b1;
        endcase
      end
      ST_T2: begin
        // Second operand (Ry) on the bus; G captures A op bus.
        bus.bus_sel  = BUS_REG;
        bus.rout_sel = w_ry;
        bus.g_load   = 1'b1;
        bus.alu_op   = (w_op == OP_SUB);
      end
      ST_T3: begin
        bus.bus_sel = BUS_G;
        w_load_en   = 1'b1;
        bus.done    = 1'b1;
      end
      default: ;
    endcase
  end

  // The destination is always Rx, so both strobe vectors share one select.
  reg_sel_decoder u_load_dec (
    .i_en     (w_load_en),
    .i_sel    (w_rx),
    .o_onehot (w_reg_load)
  );

  reg_sel_decoder u_clear_dec (
    .i_en     (w_clear_en),
    .i_sel    (w_rx),
    .o_onehot (w_reg_clear)
  );

  assign bus.reg_load  = w_reg_load;
  assign bus.reg_clear = w_reg_clear;

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
// Directed bench for datapath_sequencer. A small datapath (R0..R3, A, G,
// external data) is driven by the sequencer's strobes so register contents
// can be checked against hand-computed values; an instruction-level model
// predicts the full control frame for every cycle.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;

  logic clk;
  logic rst_n;

  datapath_sequencer_if bus_if ();

  datapath_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Controlled datapath
  // ---------------------------------------------------------------------------
  logic [7:0] data_in;
  logic [7:0] r_file [4];
  logic [7:0] a_reg;
  logic [7:0] g_reg;
  logic [7:0] bus_val;

  always_comb begin
    case (bus_if.bus_sel)
      2'b01:   bus_val = data_in;
      2'b10:   bus_val = r_file[bus_if.rout_sel];
      2'b11:   bus_val = g_reg;
      default: bus_val = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus_if.reg_clear[i]) r_file[i] <= 8'h00;
      else if (bus_if.reg_load[i]) r_file[i] <= bus_val;
    end
    if (bus_if.a_load) a_reg <= bus_val;
    if (bus_if.g_load) g_reg <= bus_if.alu_op ? (a_reg - bus_val) : (a_reg + bus_val);
  end

  // ---------------------------------------------------------------------------
  // Instruction-level model: on accept, queue the control frame of each cycle
  // the instruction occupies; an empty queue means the sequencer is idle.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       ready;
    logic       done;
    logic       err;
    logic [3:0] reg_load;
    logic [3:0] reg_clear;
    logic       a_load;
    logic       g_load;
    logic       alu_op;
    logic [1:0] bus_sel;
    logic [1:0] rout_sel;
  } frame_t;

  frame_t exp_q[$];

  function automatic frame_t idle_frame();
    frame_t f = '0;
    f.ready = 1'b1;
    return f;
  endfunction

  task automatic push_instr(input logic [7:0] ins);
    frame_t f;
    int op, rx, ry;
    op = int'(ins[7:5]);
    rx = int'(ins[4:3]);
    ry = int'(ins[2:1]);
    f = '0;
    case (op)
      0: begin f.reg_clear = 4'(1 << rx); f.done = 1'b1; exp_q.push_back(f); end
      1: begin f.bus_sel = 2'd1; f.reg_load = 4'(1 << rx); f.done = 1'b1; exp_q.push_back(f); end
      2: begin
        f.bus_sel = 2'd2; f.rout_sel = 2'(ry); f.reg_load = 4'(1 << rx); f.done = 1'b1;
        exp_q.push_back(f);
      end
      3, 4: begin
        f.bus_sel = 2'd2; f.rout_sel = 2'(rx); f.a_load = 1'b1;
        exp_q.push_back(f);
        f = '0;
        f.bus_sel = 2'd2; f.rout_sel = 2'(ry); f.g_load = 1'b1; f.alu_op = (op == 4);
        exp_q.push_back(f);
        f = '0;
        f.bus_sel = 2'd3; f.reg_load = 4'(1 << rx); f.done = 1'b1;
        exp_q.push_back(f);
      end
      default: begin f.err = 1'b1; exp_q.push_back(f); end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() != 0) void'(exp_q.pop_front());
    else if (bus_if.start) push_instr(bus_if.instr);
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------
  int frame_checks = 0;
  int frame_errors = 0;
  int cycle = 0;

  always @(negedge clk) begin
    frame_t got, exp_f;
    cycle++;
    got = {bus_if.ready, bus_if.done, bus_if.err, bus_if.reg_load, bus_if.reg_clear,
           bus_if.a_load, bus_if.g_load, bus_if.alu_op, bus_if.bus_sel, bus_if.rout_sel};
    exp_f = (exp_q.size() != 0) ? exp_q[0] : idle_frame();
    frame_checks++;
    if (got !== exp_f) begin
      frame_errors++;
      $display("FAIL frame cycle %0d: got %05h expected %05h", cycle, got, exp_f);
    end
  end

  // ---------------------------------------------------------------------------
  // Literal checks and stimulus
  // ---------------------------------------------------------------------------
  int lit_checks = 0;
  int lit_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    lit_checks++;
    if (actual !== expected) begin
      lit_errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.ready === 1'b1) seen = 1'b1;
    end
    check("ready_timeout", 32'(seen), 32'd1);
  endtask

  // Issue one instruction, measure cycles from accept edge to done/err, then
  // step past the final edge so the datapath reflects the result.
  task automatic exec(input string name, input logic [7:0] ins, input logic [7:0] din,
                      input int exp_lat, input logic exp_err);
    bit seen = 1'b0;
    int lat = 0;
    logic got_err = 1'b0;
    logic got_done = 1'b0;
    wait_ready();
    bus_if.start = 1'b1;
    bus_if.instr = ins;
    data_in      = din;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1 || bus_if.err === 1'b1) begin
        seen = 1'b1;
        lat = i;
        got_err = bus_if.err;
        got_done = bus_if.done;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_err"}, 32'(got_err), 32'(exp_err));
    check({name, "_done"}, 32'(got_done), 32'(!exp_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.instr = 8'h00;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(bus_if.ready), 32'd1);
    check("reset_strobes", {bus_if.reg_load, bus_if.reg_clear, bus_if.done, bus_if.err,
                            bus_if.bus_sel}, 32'd0);
    rst_n = 1'b1;

    // Reset while an ADD sits in T2: everything returns to idle at once.
    wait_ready();
    bus_if.start = 1'b1;
    bus_if.instr = 8'h62;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    @(posedge clk);
    #2 check("t2_g_load_before_reset", 32'(bus_if.g_load), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ready", 32'(bus_if.ready), 32'd1);
    check("async_reset_strobes", {bus_if.reg_load, bus_if.reg_clear, bus_if.a_load,
                                  bus_if.g_load, bus_if.done, bus_if.err, bus_if.bus_sel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LDI R2 <- 10, CLR R2
    exec("ldi_r2", 8'h30, 8'd10, 1, 1'b0);
    check("r2_after_ldi", 32'(r_file[2]), 32'd10);
    exec("clr_r2", 8'h10, 8'd0, 1, 1'b0);
    check("r2_after_clr", 32'(r_file[2]), 32'd0);

    // LDI R1 <- 5, MOV R3,R1
    exec("ldi_r1", 8'h28, 8'd5, 1, 1'b0);
    exec("mov_r3_r1", 8'h5A, 8'd0, 1, 1'b0);
    check("r3_after_mov", 32'(r_file[3]), 32'd5);

    // R0 = 7; ADD R0,R1 -> 12; SUB R0,R0 -> 0; R0 = 3; SUB R0,R1 -> FE
    exec("ldi_r0_7", 8'h20, 8'd7, 1, 1'b0);
    exec("add_r0_r1", 8'h62, 8'd0, 3, 1'b0);
    check("r0_after_add", 32'(r_file[0]), 32'd12);
    exec("sub_r0_r0", 8'h80, 8'd0, 3, 1'b0);
    check("r0_after_sub_self", 32'(r_file[0]), 32'd0);
    exec("ldi_r0_3", 8'h20, 8'd3, 1, 1'b0);
    exec("sub_r0_r1", 8'h82, 8'd0, 3, 1'b0);
    check("r0_after_sub", 32'(r_file[0]), 32'hFE);

    // MOV R2,R2 keeps the value
    exec("ldi_r2_9", 8'h30, 8'd9, 1, 1'b0);
    exec("mov_r2_r2", 8'h54, 8'd0, 1, 1'b0);
    check("r2_after_self_mov", 32'(r_file[2]), 32'd9);

    // Illegal opcode: err pulse, no register change
    exec("illegal", 8'hE0, 8'd0, 1, 1'b1);
    check("r0_after_illegal", 32'(r_file[0]), 32'hFE);

    // Start held through an ADD while instr shows CLR R0: must be ignored.
    wait_ready();
    bus_if.start = 1'b1;
    bus_if.instr = 8'h62;
    @(posedge clk);
    #1 bus_if.instr = 8'h00;
    check("busy_ready_low", 32'(bus_if.ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 bus_if.start = 1'b0;
    check("r0_after_busy_add", 32'(r_file[0]), 32'h03);
    @(negedge clk);
    check("idle_after_busy", 32'(bus_if.ready), 32'd1);
    repeat (2) @(negedge clk);
    check("r0_not_cleared", 32'(r_file[0]), 32'h03);

    $display("Result: errors=%0d of %0d checks", frame_errors + lit_errors,
             frame_checks + lit_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle controller that sequences a small register-file datapath: NREG Register_8bit instances, accumulator A, ALU result register G, and a shared 8-bit bus.
- Accepts one 8-bit instruction per Start/Ready handshake.
- Decodes it and, over 1–3 cycles, drives the per-register Load/Clear strobes, bus mux select, ALU op and temporary-register loads.
- Pulses Done when the instruction completes.

Parameters:
- NREG, 4, number of general registers; fixed at 4 by the 2-bit register fields.
- W, 8, data width of the controlled datapath; informational only, no W-wide logic inside.

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous active-low reset
- Start  in  1  instruction valid
- Instr  in  8  instruction: [7:5] opcode, [4:3] Rx (destination), [2:1] Ry (source), [0] reserved (ignored)
- Ready  out  1  high in IDLE; instruction accepted on Start&&Ready
- Done  out  1  one-cycle pulse in the final cycle of a legal instruction
- Err  out  1  one-cycle pulse for an illegal opcode
- Reg_load  out  NREG  one-hot load strobes to the general registers
- Reg_clear  out  NREG  one-hot clear strobes to the general registers
- A_load  out  1  load accumulator A from bus
- G_load  out  1  load G from ALU (A op bus)
- Alu_op  out  1  0 = add, 1 = subtract
- Bus_sel  out  2  bus source: 00 none, 01 external Data_in, 10 register Rout_sel, 11 G
- Rout_sel  out  2  register index driven onto the bus when Bus_sel=10

Behaviour:
- Reset (Resetn low, asynchronous): state = IDLE, IR = 0.
  - All strobes are 0: Reg_load, Reg_clear, A_load, G_load, Done, Err.
  - Alu_op = 0, Bus_sel = 00, Rout_sel = 00, Ready = 1.
  - Reset mid-instruction aborts it; no partial strobes follow.
- Output timing: all outputs decode from registered state and IR only (Moore); no Instr/Start-to-output combinational path.
- States: IDLE, T1, T2, T3.
- IDLE:
  - On Start=1, IR <= Instr and go to T1.
  - Start in any other state is ignored. Ready = 0 outside IDLE.
- Opcodes and per-cycle actions:
  - 000 CLR: T1: Reg_clear[Rx]=1, Done=1 -> IDLE.
  - 001 LDI: T1: Bus_sel=01, Reg_load[Rx]=1, Done=1 -> IDLE.
  - 010 MOV: T1: Bus_sel=10, Rout_sel=Ry, Reg_load[Rx]=1, Done=1 -> IDLE.
  - 011 ADD and 100 SUB:
    - T1: Bus_sel=10, Rout_sel=Rx, A_load=1.
    - T2: Bus_sel=10, Rout_sel=Ry, G_load=1, Alu_op = (opcode==100).
    - T3: Bus_sel=11, Reg_load[Rx]=1, Done=1 -> IDLE.
  - 101–111 illegal: T1: Err=1, Done=0, no strobes -> IDLE.
- Latency from accept edge to Done: 1 cycle for CLR/LDI/MOV, 3 cycles for ADD/SUB. Back-to-back throughput = latency + 1 (IDLE cycle).
- Rx == Ry is legal:
  - MOV R,R reloads the same value.
  - SUB R,R yields 0.
- Never more than one bit of Reg_load or Reg_clear is set, and never both vectors in the same cycle.
- Alu_op is don't-care outside T2 but is driven 0.
- Arithmetic is performed by the datapath, modulo 2^W, no carry out. The sequencer has no flags.

Decomposition:
- Shared package: opcode constants (OP_CLR..OP_SUB), state encoding, Bus_sel encodings (BUS_NONE, BUS_EXT, BUS_REG, BUS_G), IR field bit positions.
- One sub-module: reg_sel_decoder, a 2-to-4 one-hot decoder with enable, instantiated twice (load and clear vectors).

Test Plan:
- Reset, then LDI: Resetn low mid-ADD in T2 -> all strobes 0 and Ready=1 immediately. After release, LDI R2 (Instr=8'b001_10_00_0) with Data_in=8'd10 -> next cycle Bus_sel=01, Reg_load=0100, Done=1; R2 reads 10.
- CLR: CLR R2 (8'b000_10_00_0) -> Reg_clear=0100 for one cycle, Done=1; R2 reads 0.
- MOV: LDI R1=5, then MOV R3,R1 (8'b010_11_01_0) -> Rout_sel=01, Reg_load=1000, Done; R3 reads 5.
- ADD/SUB sequence with R0=7, R1=5:
  - ADD R0,R1 (8'b011_00_01_0) -> T1 A_load, T2 G_load with Alu_op=0, T3 Bus_sel=11 and Reg_load=0001, Done 3 cycles after accept; R0 reads 12.
  - SUB R0,R0 -> R0 reads 0.
  - R0=3, SUB R0,R1 -> 8'hFE.
- Illegal opcode and busy: Instr=8'b111_00_00_0 -> Err pulse for one cycle, Done=0, no strobes, back to IDLE. Start held high during ADD T1–T3 -> ignored, Ready=0, no second accept until IDLE.
